// File: rtl/ad9945_cfg_sched_if.sv
// Write-request bundle for the AD9945 config scheduler:
// host register write port plus the AGC gain update port.
interface ad9945_cfg_sched_if;
    logic       host_valid;
    logic       host_ready;
    logic [1:0] host_addr;
    logic [9:0] host_data;
    logic       agc_valid;
    logic       agc_ready;
    logic [9:0] agc_gain;

    modport master (
        output host_valid, host_addr, host_data,
        output agc_valid, agc_gain,
        input  host_ready, agc_ready
    );

    modport slave (
        input  host_valid, host_addr, host_data,
        input  agc_valid, agc_gain,
        output host_ready, agc_ready
    );
endinterface

// File: rtl/ad9945_cfg_sched.sv
// AD9945 config scheduler: shadow regs, host/AGC arbitration, cfg_en framing.
// Optional boot-time frame enabled by AD9945_SCHED_AUTOCFG_EN.
module ad9945_cfg_sched #(
    parameter int PULSE_CYCLES   = 48,
    parameter int FRAME_CYCLES   = 1152,
    parameter int GAP_CYCLES     = 48,
    parameter int STARTUP_CYCLES = 100000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    ad9945_cfg_sched_if.slave  wr,
    output logic [6:0]         Oper,
    output logic [6:0]         Ctrl,
    output logic [7:0]         Clamp,
    output logic [9:0]         VGA_Gain,
    output logic               cfg_en,
    output logic               busy,
    output logic [15:0]        frame_cnt
);

    localparam int M0   = (PULSE_CYCLES > FRAME_CYCLES) ? PULSE_CYCLES : FRAME_CYCLES;
    localparam int M1   = (M0 > GAP_CYCLES) ? M0 : GAP_CYCLES;
    localparam int CMAX = (M1 > STARTUP_CYCLES) ? M1 : STARTUP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_WAIT,
        S_GAP,
        S_BOOT
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          dirty;
    logic          launch;
    logic          boot_done;

    logic [6:0]    oper_sh;
    logic [6:0]    ctrl_sh;
    logic [7:0]    clamp_sh;
    logic [9:0]    gain_sh;

    logic          host_wr;
    logic          agc_wr;

    // Host has fixed priority; a blocked AGC request simply waits.
    assign wr.host_ready = 1'b1;
    assign wr.agc_ready  = ~wr.host_valid;
    assign host_wr       = wr.host_valid;
    assign agc_wr        = wr.agc_valid & ~wr.host_valid;

    assign cfg_en = (state == S_PULSE);
    assign busy   = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch    = 1'b0;
        boot_done = 1'b0;
        if (cnt != '0) cnt_nxt = cnt - 1'b1;
        unique case (state)
            S_IDLE: begin
                if (dirty) begin
                    state_nxt = S_PULSE;
                    cnt_nxt   = CW'(PULSE_CYCLES - 1);
                    launch    = 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt == '0) begin
                    state_nxt = S_WAIT;
                    cnt_nxt   = CW'(FRAME_CYCLES - 1);
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    state_nxt = S_GAP;
                    cnt_nxt   = CW'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (cnt == '0) begin
                    if (dirty) begin
                        state_nxt = S_PULSE;
                        cnt_nxt   = CW'(PULSE_CYCLES - 1);
                        launch    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_BOOT: begin
                if (cnt == '0) begin
                    state_nxt = S_IDLE;
                    boot_done = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
`ifdef AD9945_SCHED_AUTOCFG_EN
            state <= S_BOOT;
            cnt   <= CW'(STARTUP_CYCLES - 1);
`else
            state <= S_IDLE;
            cnt   <= '0;
`endif
            dirty     <= 1'b0;
            frame_cnt <= '0;
            oper_sh   <= '0;
            ctrl_sh   <= '0;
            clamp_sh  <= 8'd128;
            gain_sh   <= '0;
            Oper      <= '0;
            Ctrl      <= '0;
            Clamp     <= 8'd128;
            VGA_Gain  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (host_wr) begin
                unique case (wr.host_addr)
                    2'd0: oper_sh  <= wr.host_data[6:0];
                    2'd1: ctrl_sh  <= wr.host_data[6:0];
                    2'd2: clamp_sh <= wr.host_data[7:0];
                    2'd3: gain_sh  <= wr.host_data;
                    default: ;
                endcase
            end else if (agc_wr) begin
                gain_sh <= wr.agc_gain;
            end
            // Live values only move at launch; a same-cycle write re-arms dirty.
            if (launch) begin
                Oper      <= oper_sh;
                Ctrl      <= ctrl_sh;
                Clamp     <= clamp_sh;
                VGA_Gain  <= gain_sh;
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (host_wr || agc_wr || boot_done) dirty <= 1'b1;
            else if (launch) dirty <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ad9945_cfg_sched.sv
// Directed bench for ad9945_cfg_sched: vector table plus
// hand-written sequences for arbitration, coalescing and reset.
module tb_ad9945_cfg_sched;

    logic        sys_clk;
    logic        sys_rst;
    logic [6:0]  Oper;
    logic [6:0]  Ctrl;
    logic [7:0]  Clamp;
    logic [9:0]  VGA_Gain;
    logic        cfg_en;
    logic        busy;
    logic [15:0] frame_cnt;

    int checks;
    int failures;

    ad9945_cfg_sched_if bus ();

    ad9945_cfg_sched #(
        .PULSE_CYCLES   (48),
        .FRAME_CYCLES   (1152),
        .GAP_CYCLES     (48),
        .STARTUP_CYCLES (200)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .wr        (bus.slave),
        .Oper      (Oper),
        .Ctrl      (Ctrl),
        .Clamp     (Clamp),
        .VGA_Gain  (VGA_Gain),
        .cfg_en    (cfg_en),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]  addr;
        logic [9:0]  data;
        logic [6:0]  oper;
        logic [6:0]  ctrl;
        logic [7:0]  clamp;
        logic [9:0]  gain;
        logic [15:0] fcnt;
    } vec_t;

    vec_t vt [4];

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Walks a frame from its launch cycle until busy drops.
    task automatic measure(output int pw, output int bw);
        pw = 0;
        bw = 0;
        while (busy && bw < 3000) begin
            if (cfg_en) pw++;
            bw++;
            tick();
        end
    endtask

    task automatic host_write(input logic [1:0] a, input logic [9:0] d);
        bus.host_valid = 1'b1;
        bus.host_addr  = a;
        bus.host_data  = d;
        tick();
        bus.host_valid = 1'b0;
    endtask

    initial begin
        int pw;
        int bw;
        int n;
        int hits;
        checks   = 0;
        failures = 0;
        sys_rst        = 1'b1;
        bus.host_valid = 1'b0;
        bus.host_addr  = '0;
        bus.host_data  = '0;
        bus.agc_valid  = 1'b0;
        bus.agc_gain   = '0;

        vt[0] = '{2'd3, 10'h155, 7'h00, 7'h00, 8'd128, 10'h155, 16'd1};
        vt[1] = '{2'd0, 10'h3FF, 7'h7F, 7'h00, 8'd128, 10'h155, 16'd2};
        vt[2] = '{2'd1, 10'h2A5, 7'h7F, 7'h25, 8'd128, 10'h155, 16'd3};
        vt[3] = '{2'd2, 10'h1C3, 7'h7F, 7'h25, 8'hC3, 10'h155, 16'd4};

        repeat (3) tick();
        sys_rst = 1'b0;

`ifdef AD9945_SCHED_AUTOCFG_EN
        // Cycle 0 is the first cycle after reset release.
        n    = 0;
        hits = 0;
        while (n < 50) begin
            if (!busy || cfg_en) hits++;
            tick();
            n++;
        end
        chk("boot_busy", hits, 0);
        host_write(2'd1, 10'h005);
        n++;
        while (!cfg_en && n < 400) begin
            tick();
            n++;
        end
        chk("boot_launch_cycle", n, 201);
        chk("boot_ctrl", Ctrl, 7'h05);
        chk("boot_clamp", Clamp, 8'd128);
        chk("boot_fcnt", frame_cnt, 16'd1);
        measure(pw, bw);
        chk("boot_pulse", pw, 48);
        chk("boot_busy_len", bw, 1248);
        repeat (100) tick();
        chk("boot_single_frame", frame_cnt, 16'd1);
`else
        chk("rst_oper", Oper, 7'h00);
        chk("rst_ctrl", Ctrl, 7'h00);
        chk("rst_clamp", Clamp, 8'd128);
        chk("rst_gain", VGA_Gain, 10'h000);
        chk("rst_cfg_en", cfg_en, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fcnt", frame_cnt, 16'd0);
        chk("rst_host_ready", bus.host_ready, 1'b1);
        chk("rst_agc_ready", bus.agc_ready, 1'b1);

        hits = 0;
        for (int i = 0; i < 5000; i++) begin
            if (cfg_en || busy) hits++;
            tick();
        end
        chk("idle_quiet", hits, 0);
        chk("idle_fcnt", frame_cnt, 16'd0);

        for (int i = 0; i < 4; i++) begin
            host_write(vt[i].addr, vt[i].data);
            chk("vec_n1_cfg_en", cfg_en, 1'b0);
            chk("vec_n1_fcnt", frame_cnt, vt[i].fcnt - 16'd1);
            tick();
            chk("vec_cfg_en", cfg_en, 1'b1);
            chk("vec_oper", Oper, vt[i].oper);
            chk("vec_ctrl", Ctrl, vt[i].ctrl);
            chk("vec_clamp", Clamp, vt[i].clamp);
            chk("vec_gain", VGA_Gain, vt[i].gain);
            chk("vec_fcnt", frame_cnt, vt[i].fcnt);
            measure(pw, bw);
            chk("vec_pulse", pw, 48);
            chk("vec_busy_len", bw, 1248);
        end

        // Simultaneous host and AGC requests.
        bus.host_valid = 1'b1;
        bus.host_addr  = 2'd2;
        bus.host_data  = 10'h0FF;
        bus.agc_valid  = 1'b1;
        bus.agc_gain   = 10'h2AA;
        #1;
        chk("arb_agc_blocked", bus.agc_ready, 1'b0);
        chk("arb_host_ready", bus.host_ready, 1'b1);
        tick();
        bus.host_valid = 1'b0;
        #1;
        chk("arb_agc_free", bus.agc_ready, 1'b1);
        tick();
        bus.agc_valid = 1'b0;
        chk("arb_cfg_en", cfg_en, 1'b1);
        chk("arb_clamp", Clamp, 8'hFF);
        chk("arb_gain_old", VGA_Gain, 10'h155);
        chk("arb_fcnt", frame_cnt, 16'd5);
        n = 0;
        while (cfg_en && n < 100) begin
            tick();
            n++;
        end
        while (!cfg_en && n < 2000) begin
            tick();
            n++;
        end
        chk("arb_relaunch_at", n, 1248);
        chk("arb_gain_new", VGA_Gain, 10'h2AA);
        chk("arb_clamp_kept", Clamp, 8'hFF);
        chk("arb_fcnt2", frame_cnt, 16'd6);
        measure(pw, bw);
        chk("arb_pulse2", pw, 48);

        // Coalescing of five AGC writes during WAIT.
        host_write(2'd0, 10'h011);
        tick();
        chk("coal_launch", cfg_en, 1'b1);
        chk("coal_oper", Oper, 7'h11);
        chk("coal_fcnt", frame_cnt, 16'd7);
        repeat (60) tick();
        for (int i = 0; i < 5; i++) begin
            bus.agc_valid = 1'b1;
            bus.agc_gain  = 10'h010 + 10'(i);
            tick();
        end
        bus.agc_valid = 1'b0;
        chk("coal_wait_gain", VGA_Gain, 10'h2AA);
        repeat (1182) tick();
        chk("coal_pre_cfg_en", cfg_en, 1'b0);
        chk("coal_pre_busy", busy, 1'b1);
        chk("coal_pre_gain", VGA_Gain, 10'h2AA);
        tick();
        chk("coal_relaunch", cfg_en, 1'b1);
        chk("coal_gain", VGA_Gain, 10'h014);
        chk("coal_fcnt", frame_cnt, 16'd8);

        // Reset in the middle of PULSE.
        repeat (10) tick();
        chk("midrst_pre_cfg_en", cfg_en, 1'b1);
        sys_rst = 1'b1;
        tick();
        chk("midrst_cfg_en", cfg_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_oper", Oper, 7'h00);
        chk("midrst_clamp", Clamp, 8'd128);
        chk("midrst_gain", VGA_Gain, 10'h000);
        chk("midrst_fcnt", frame_cnt, 16'd0);
        sys_rst = 1'b0;
        tick();
        host_write(2'd3, 10'h0AB);
        tick();
        chk("post_rst_cfg_en", cfg_en, 1'b1);
        chk("post_rst_gain", VGA_Gain, 10'h0AB);
        chk("post_rst_oper", Oper, 7'h00);
        chk("post_rst_clamp", Clamp, 8'd128);
        chk("post_rst_fcnt", frame_cnt, 16'd1);
        measure(pw, bw);
        chk("post_rst_pulse", pw, 48);
        chk("post_rst_busy_len", bw, 1248);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ad9945_cfg_sched.md
Name: ad9945_cfg_sched

Overview:
- Configuration scheduler in front of the AD9945 serial-config block.
- Holds shadow copies of the Operation, Control, Clamp and VGA_Gain registers.
- Arbitrates register writes from two requesters: a host write port and an auto-gain (AGC) loop.
- Sequences cfg_en pulses so that each serial frame sees stable register values, and coalesces writes that arrive mid-frame into one follow-up frame.

Parameters:
- PULSE_CYCLES, 48: sys_clk cycles cfg_en is held high (3 sck periods at div-16).
- FRAME_CYCLES, 1152: sys_clk cycles waited after the pulse for a 64-bit frame to finish, plus margin.
- GAP_CYCLES, 48: minimum cfg_en-low cycles between frames, so the sck-domain edge detect re-arms.
- STARTUP_CYCLES, 100000: delay after reset before the automatic first frame (optional feature only).

Ports:
- sys_clk  in  1  system clock, 100 MHz
- sys_rst  in  1  synchronous reset, active-high
- host_valid  in  1  host write request
- host_ready  out  1  host write accepted when host_valid & host_ready
- host_addr  in  2  0=Oper, 1=Ctrl, 2=Clamp, 3=VGA_Gain
- host_data  in  10  write data, LSB-aligned; bits above the register width are ignored
- agc_valid  in  1  AGC gain update request
- agc_ready  out  1  AGC update accepted when agc_valid & agc_ready
- agc_gain  in  10  new VGA_Gain value
- Oper  out  7  live Operation value to the serial block
- Ctrl  out  7  live Control value
- Clamp  out  8  live Clamp value
- VGA_Gain  out  10  live gain value
- cfg_en  out  1  frame trigger to the serial block
- busy  out  1  high in PULSE, WAIT and GAP
- frame_cnt  out  16  number of frames launched; wraps at 0xFFFF->0

Behaviour:
- One clock domain: sys_clk. Reset is synchronous and active-high (sys_rst).
- Reset values:
  - Shadow and live registers: Oper=0, Ctrl=0, Clamp=128, VGA_Gain=0.
  - cfg_en=0, busy=0, frame_cnt=0, dirty=0, state=IDLE.
  - host_ready=1 and agc_ready=1 from the first cycle after reset.
- Arbitration:
  - host_ready is always 1.
  - agc_ready = ~host_valid, i.e. fixed host priority.
  - If both request in the same cycle, only the host write lands. The AGC request stays pending, since its valid is held until ready.
- Accepted write:
  - Updates the shadow register on the next edge and sets dirty.
  - Writes are accepted in every state. Live outputs never change except at frame launch.
  - A host write to addr 3 and an AGC write are equivalent.
- State machine:
  - IDLE: if dirty -> PULSE. On entry to PULSE: copy shadow -> live, clear dirty, frame_cnt+1.
    - A write accepted in that same cycle re-sets dirty; the set wins over the clear.
  - PULSE: cfg_en=1 for exactly PULSE_CYCLES cycles -> WAIT.
  - WAIT: cfg_en=0 for FRAME_CYCLES cycles -> GAP.
  - GAP: cfg_en=0 for GAP_CYCLES cycles, then -> PULSE if dirty (with the same copy/clear/increment actions), otherwise -> IDLE.
- Coalescing: any number of writes during PULSE, WAIT or GAP produce exactly one follow-up frame, using the last values written.
- Latency: a write in IDLE at cycle N gives cfg_en=1 and the live update at cycle N+2 (shadow at N+1, launch at N+2).
- Counter: a single down-counter, reloaded on each state entry and wide enough for max(parameters). Transition occurs when it reaches 0.
- Reset mid-frame:
  - Outputs return to reset values and cfg_en drops immediately.
  - Shadow values are lost.
  - The serial block finishes any frame already in flight on its own.

Optional Feature:
- Macro: AD9945_SCHED_AUTOCFG_EN.
- Defined:
  - After reset, the block sits in state BOOT for STARTUP_CYCLES cycles with busy=1, then sets dirty.
  - This launches one frame with the reset defaults (Clamp=128).
  - Writes accepted during BOOT are merged into that first frame.
- Undefined:
  - No BOOT state.
  - The block stays in IDLE until the first write; STARTUP_CYCLES is unused.

Test Plan:
- Reset, no writes, macro undefined -> cfg_en stays 0 for 5000 cycles; Clamp=128, frame_cnt=0, busy=0.
- Host writes addr 3, data 0x155, in IDLE -> VGA_Gain=0x155 two cycles later; cfg_en high for exactly 48 cycles; busy high for 48+1152+48 cycles; frame_cnt=1.
- Host addr 2 data 0x0FF and AGC gain 0x2AA in the same cycle -> agc_ready=0 that cycle, Clamp=0xFF. AGC is accepted the next cycle and a second frame carries VGA_Gain=0x2AA; frame_cnt=2.
- Five AGC writes (0x010..0x014) during WAIT -> exactly one follow-up frame, launched GAP_CYCLES after WAIT ends, with VGA_Gain=0x014; live values are unchanged before that launch.
- sys_rst asserted mid-PULSE -> cfg_en=0 on the next cycle; all outputs at reset values; a subsequent write launches a normal frame.
- Macro defined, STARTUP_CYCLES=200, host Ctrl=0x05 written at cycle 50 -> a single frame launches at cycle 201 with Ctrl=5, Clamp=128.
